mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter: WAIT_STATES, 1, extra memory cycles per access; legal range 0..7.
REQ-002 SHALL have these ports, clock and reset first:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- ibus_address  in  32  instruction-side byte address.
- ibus_byteenable  in  4  instruction-side byte lanes.
- ibus_read  in  1  instruction-side read request.
- ibus_write  in  1  instruction-side write request.
- ibus_wrdata  in  32  instruction-side write data.
- ibus_rddata  out  32  instruction-side read data.
- ibus_stall  out  1  instruction side must hold its request.
- dbus_address  in  32  data-side byte address.
- dbus_byteenable  in  4  data-side byte lanes.
- dbus_read  in  1  data-side read request.
- dbus_write  in  1  data-side write request.
- dbus_wrdata  in  32  data-side write data.
- dbus_rddata  out  32  data-side read data.
- dbus_stall  out  1  data side must hold its request.
- mem_address  out  30  word address to the single-port RAM.
- mem_byteenable  out  4  RAM byte lanes.
- mem_read  out  1  RAM read strobe.
- mem_write  out  1  RAM write strobe.
- mem_wrdata  out  32  RAM write data.
- mem_rddata  in  32  RAM read data; valid by the end of the last BUSY cycle.

Function
REQ-003 SHALL treat a port as requesting when its read or write input is 1; if both are 1, SHALL perform a write.
REQ-004 SHALL implement FSM states IDLE, BUSY and DONE, plus an owner register (IBUS/DBUS) and a 3-bit wait counter.
REQ-005 From IDLE with any request, SHALL move to BUSY at the next edge and latch owner, address[31:2], byteenable, wrdata and operation.
- If both ports request, DBUS wins.
REQ-006 SHALL stay in BUSY for exactly WAIT_STATES+1 cycles, counted by the wait counter.
- mem_address, mem_byteenable and mem_wrdata SHALL hold the latched values for every BUSY cycle.
- mem_read or mem_write, per the latched operation, SHALL be 1 for every BUSY cycle.
REQ-007 On the edge ending the last BUSY cycle, SHALL capture mem_rddata into a read-data register and enter DONE.
- For a write, SHALL leave the read-data register unchanged.
REQ-008 In DONE, the owner's stall SHALL be 0.
- ibus_rddata and dbus_rddata SHALL both always show the read-data register.
REQ-009 xbus_stall SHALL equal (xbus_read|xbus_write) & ~(state==DONE & owner==x), combinationally.
- Therefore a port with no request never stalls.
- With WAIT_STATES=1, a request first seen in cycle 0 in IDLE completes with stall=0 in cycle 3.
REQ-010 In DONE, if the non-owner port is requesting, SHALL grant it and enter BUSY at the next edge; otherwise SHALL enter IDLE.
- SHALL never re-grant the DONE owner on that edge, since its request is the completed one. This guarantees alternation and no starvation under continuous load.
REQ-011 mem_read and mem_write SHALL be 0 in IDLE and DONE, and SHALL never both be 1.
REQ-012 Request inputs changing while their port is stalled is a protocol violation.
- The arbiter SHALL ignore such changes and use the latched values.
REQ-013 Any mem_address bits beyond those derived from address[31:2] SHALL NOT be used; byteenable SHALL pass through unmodified, including 4'b0000.

Reset
REQ-014 When rst_n is 0 at an edge: state=IDLE, owner=IBUS, wait counter=0, read-data register=0, latched address/byteenable/wrdata/operation=0.
REQ-015 Reset asserted mid-access SHALL abort the access.
- mem_read and mem_write SHALL be 0 in the cycle after the reset edge.
- No DONE cycle is produced for the aborted access.
REQ-016 During reset, the stall outputs SHALL follow REQ-009 with state=IDLE, so any requester stays stalled until granted.

Verification
REQ-017 Single read: WAIT_STATES=1; ibus_read=1, ibus_address=0x0000_0010 at cycle 0; mem_rddata=0x2402_0005 -> mem_read=1 and mem_address=0x4 in cycles 1-2; ibus_stall=0 and ibus_rddata=0x2402_0005 in cycle 3.
REQ-018 Collision: ibus_read and dbus_write (addr 0x100, data 0xDEADBEEF, be 4'b1111) both at cycle 0 -> dbus served first; mem_write=1 in cycles 1-2; dbus_stall=0 in cycle 3; ibus in BUSY cycles 4-5; ibus_stall=0 in cycle 6.
REQ-019 Continuous load: both ports request every cycle for 20 accesses -> owners strictly alternate D,I,D,I...; neither stall exceeds 2*(WAIT_STATES+2) cycles per access.
REQ-020 WAIT_STATES=0: dbus_read at cycle 0 -> BUSY only in cycle 1; dbus_stall=0 in cycle 2.
- WAIT_STATES=7: BUSY in cycles 1-8; dbus_stall=0 in cycle 9.
REQ-021 Reset mid-access: dbus_write granted, rst_n=0 during the first BUSY cycle -> mem_write=0 the next cycle, state IDLE, read-data register=0, no DONE cycle.
REQ-022 Byte write: dbus_write with be=4'b0010 and addr 0x203 -> mem_address=0x80, mem_byteenable=4'b0010; a following dbus_read of the same word returns the modified byte only.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single-port RAM with a
// fixed number of wait states; data side wins ties, owners alternate under load.
module mem_bus_arbiter #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ibus_address,
    input  logic [3:0]  ibus_byteenable,
    input  logic        ibus_read,
    input  logic        ibus_write,
    input  logic [31:0] ibus_wrdata,
    output logic [31:0] ibus_rddata,
    output logic        ibus_stall,
    input  logic [31:0] dbus_address,
    input  logic [3:0]  dbus_byteenable,
    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic [31:0] dbus_wrdata,
    output logic [31:0] dbus_rddata,
    output logic        dbus_stall,
    output logic [29:0] mem_address,
    output logic [3:0]  mem_byteenable,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wrdata,
    input  logic [31:0] mem_rddata
);

    localparam int unsigned DW  = 32;
    localparam int unsigned BEW = 4;
    localparam int unsigned MAW = 30;
    localparam int unsigned CW  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IBUS = 1'b0,
        OWN_DBUS = 1'b1
    } owner_t;

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    logic [CW-1:0]    wait_q, wait_d;
    logic [DW-1:0]    rdata_q, rdata_d;
    logic [MAW-1:0]   addr_q, addr_d;
    logic [BEW-1:0]   be_q, be_d;
    logic [DW-1:0]    wdata_q, wdata_d;
    logic             wr_q, wr_d;

    logic             ireq, dreq;
    logic             grant_en;
    logic             grant_dbus;

    assign ireq = ibus_read | ibus_write;
    assign dreq = dbus_read | dbus_write;

    // Address byte-offset bits never reach the word-addressed RAM.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{ibus_address[1:0], dbus_address[1:0]};

    // Next-state: grant selection, wait counting, read-data capture.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wait_d     = wait_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        grant_en   = 1'b0;
        grant_dbus = 1'b0;

        case (state_q)
            IDLE: begin
                if (dreq) begin
                    grant_en   = 1'b1;
                    grant_dbus = 1'b1;
                end else if (ireq) begin
                    grant_en   = 1'b1;
                end
            end
            BUSY: begin
                if (wait_q == CW'(WAIT_STATES)) begin
                    state_d = DONE;
                    wait_d  = '0;
                    if (!wr_q) begin
                        rdata_d = mem_rddata;
                    end
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            DONE: begin
                // The finishing owner's request is the one just served.
                if (owner_q == OWN_IBUS && dreq) begin
                    grant_en   = 1'b1;
                    grant_dbus = 1'b1;
                end else if (owner_q == OWN_DBUS && ireq) begin
                    grant_en   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (grant_en) begin
            state_d = BUSY;
            wait_d  = '0;
            if (grant_dbus) begin
                owner_d = OWN_DBUS;
                addr_d  = dbus_address[31:2];
                be_d    = dbus_byteenable;
                wdata_d = dbus_wrdata;
                wr_d    = dbus_write;
            end else begin
                owner_d = OWN_IBUS;
                addr_d  = ibus_address[31:2];
                be_d    = ibus_byteenable;
                wdata_d = ibus_wrdata;
                wr_d    = ibus_write;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_IBUS;
            wait_q  <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wait_q  <= wait_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
        end
    end

    assign mem_address    = addr_q;
    assign mem_byteenable = be_q;
    assign mem_wrdata     = wdata_q;
    assign mem_read       = (state_q == BUSY) & ~wr_q;
    assign mem_write      = (state_q == BUSY) &  wr_q;

    assign ibus_rddata = rdata_q;
    assign dbus_rddata = rdata_q;

    assign ibus_stall = ireq & ~(state_q == DONE && owner_q == OWN_IBUS);
    assign dbus_stall = dreq & ~(state_q == DONE && owner_q == OWN_DBUS);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized two-master
// traffic checked against a word-level shadow memory and fairness rules.
module tb_mem_bus_arbiter;

    localparam int WS    = 1;
    localparam int BOUND = 2 * (WS + 2);

    logic        clk;
    logic        rst_n;
    logic [31:0] ibus_address, dbus_address;
    logic [3:0]  ibus_byteenable, dbus_byteenable;
    logic        ibus_read, ibus_write, dbus_read, dbus_write;
    logic [31:0] ibus_wrdata, dbus_wrdata;
    logic [31:0] ibus_rddata, dbus_rddata;
    logic        ibus_stall, dbus_stall;
    logic [29:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_read, mem_write;
    logic [31:0] mem_wrdata, mem_rddata;

    logic        s_read;
    logic [31:0] s0_rddata, s7_rddata, s0_irddata, s7_irddata;
    logic        s0_istall, s0_dstall, s7_istall, s7_dstall;
    logic [29:0] s0_maddr, s7_maddr;
    logic [3:0]  s0_mbe, s7_mbe;
    logic        s0_mrd, s0_mwr, s7_mrd, s7_mwr;
    logic [31:0] s0_mwd, s7_mwd;
    localparam logic [31:0] SHORT_DATA = 32'h5A5A_1234;

    logic [31:0] ram    [256];
    logic [31:0] shadow [256];
    logic        ram_load;

    int n_tests = 0;
    int n_fail  = 0;

    mem_bus_arbiter #(.WAIT_STATES(WS)) dut (
        .clk(clk), .rst_n(rst_n),
        .ibus_address(ibus_address), .ibus_byteenable(ibus_byteenable),
        .ibus_read(ibus_read), .ibus_write(ibus_write), .ibus_wrdata(ibus_wrdata),
        .ibus_rddata(ibus_rddata), .ibus_stall(ibus_stall),
        .dbus_address(dbus_address), .dbus_byteenable(dbus_byteenable),
        .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_wrdata(dbus_wrdata),
        .dbus_rddata(dbus_rddata), .dbus_stall(dbus_stall),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wrdata(mem_wrdata),
        .mem_rddata(mem_rddata)
    );

    mem_bus_arbiter #(.WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .rst_n(rst_n),
        .ibus_address(32'h0), .ibus_byteenable(4'h0),
        .ibus_read(1'b0), .ibus_write(1'b0), .ibus_wrdata(32'h0),
        .ibus_rddata(s0_irddata), .ibus_stall(s0_istall),
        .dbus_address(32'h40), .dbus_byteenable(4'hF),
        .dbus_read(s_read), .dbus_write(1'b0), .dbus_wrdata(32'h0),
        .dbus_rddata(s0_rddata), .dbus_stall(s0_dstall),
        .mem_address(s0_maddr), .mem_byteenable(s0_mbe),
        .mem_read(s0_mrd), .mem_write(s0_mwr), .mem_wrdata(s0_mwd),
        .mem_rddata(SHORT_DATA)
    );

    mem_bus_arbiter #(.WAIT_STATES(7)) dut_ws7 (
        .clk(clk), .rst_n(rst_n),
        .ibus_address(32'h0), .ibus_byteenable(4'h0),
        .ibus_read(1'b0), .ibus_write(1'b0), .ibus_wrdata(32'h0),
        .ibus_rddata(s7_irddata), .ibus_stall(s7_istall),
        .dbus_address(32'h40), .dbus_byteenable(4'hF),
        .dbus_read(s_read), .dbus_write(1'b0), .dbus_wrdata(32'h0),
        .dbus_rddata(s7_rddata), .dbus_stall(s7_dstall),
        .mem_address(s7_maddr), .mem_byteenable(s7_mbe),
        .mem_read(s7_mrd), .mem_write(s7_mwr), .mem_wrdata(s7_mwd),
        .mem_rddata(SHORT_DATA)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed(input int i);
        if (i == 4)   return 32'h2402_0005;
        if (i == 128) return 32'h1122_3344;
        return (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Behavioural RAM: byte-lane writes at the edge, combinational read.
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= seed(i);
        end else if (mem_write) begin
            ram[mem_address[7:0]] <= merge(ram[mem_address[7:0]], mem_wrdata, mem_byteenable);
        end
    end
    assign mem_rddata = ram[mem_address[7:0]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ibus_read = 0; ibus_write = 0; dbus_read = 0; dbus_write = 0;
    endtask

    // Randomized master state, index 0 = ibus, 1 = dbus.
    logic        act [2];
    logic        wr  [2];
    logic        both[2];
    logic [31:0] adr [2];
    logic [31:0] wd  [2];
    logic [3:0]  bes [2];
    int          lat [2];

    task automatic new_req(input int p);
        logic [7:0] word;
        word   = 8'(144 + $urandom_range(111));
        act[p] = 1;
        wr[p]  = 1'($urandom_range(1));
        both[p]= 1'($urandom_range(1));
        adr[p] = {22'b0, word, 2'($urandom_range(3))};
        wd[p]  = $urandom;
        bes[p] = 4'($urandom_range(15));
        lat[p] = 0;
    endtask

    task automatic apply();
        ibus_address = adr[0]; ibus_byteenable = bes[0]; ibus_wrdata = wd[0];
        ibus_write = act[0] & wr[0];
        ibus_read  = act[0] & (~wr[0] | both[0]);
        dbus_address = adr[1]; dbus_byteenable = bes[1]; dbus_wrdata = wd[1];
        dbus_write = act[1] & wr[1];
        dbus_read  = act[1] & (~wr[1] | both[1]);
    endtask

    initial begin
        int first0, first7, last_owner, ncomp;
        bit cont, abort;
        logic [31:0] last_rd, rd;
        logic stl;

        clk = 0; rst_n = 0; ram_load = 1; s_read = 0;
        idle_inputs();
        ibus_address = 0; dbus_address = 0; ibus_byteenable = 0; dbus_byteenable = 0;
        ibus_wrdata = 0; dbus_wrdata = 0;
        for (int i = 0; i < 256; i++) shadow[i] = seed(i);
        tick();
        ram_load = 0;

        // Reset state
        @(negedge clk);
        check("rst_istall", 32'(ibus_stall), 0);
        check("rst_dstall", 32'(dbus_stall), 0);
        check("rst_mrd", 32'(mem_read), 0);
        check("rst_mwr", 32'(mem_write), 0);
        check("rst_rddata", ibus_rddata, 0);
        check("rst_addr", 32'(mem_address), 0);
        tick();
        ibus_read = 1;
        @(negedge clk);
        check("rst_req_stall", 32'(ibus_stall), 1);
        check("rst_req_mrd", 32'(mem_read), 0);
        tick();
        ibus_read = 0; rst_n = 1;
        tick();

        // Single read
        ibus_read = 1; ibus_address = 32'h10; ibus_byteenable = 4'hF;
        @(negedge clk); check("rd_c0_stall", 32'(ibus_stall), 1);
        tick(); @(negedge clk);
        check("rd_c1_mrd", 32'(mem_read), 1);
        check("rd_c1_addr", 32'(mem_address), 32'h4);
        tick(); @(negedge clk);
        check("rd_c2_mrd", 32'(mem_read), 1);
        check("rd_c2_stall", 32'(ibus_stall), 1);
        tick(); @(negedge clk);
        check("rd_c3_stall", 32'(ibus_stall), 0);
        check("rd_c3_data", ibus_rddata, 32'h2402_0005);
        check("rd_c3_ddata", dbus_rddata, 32'h2402_0005);
        check("rd_c3_mrd", 32'(mem_read), 0);
        tick(); ibus_read = 0;
        @(negedge clk); check("rd_c4_idle", 32'(mem_read), 0);
        tick();

        // Collision: dbus write wins, then ibus read
        ibus_read = 1; ibus_address = 32'h10;
        dbus_write = 1; dbus_address = 32'h100; dbus_wrdata = 32'hDEAD_BEEF; dbus_byteenable = 4'hF;
        @(negedge clk);
        check("col_c0_dstall", 32'(dbus_stall), 1);
        check("col_c0_istall", 32'(ibus_stall), 1);
        tick(); @(negedge clk);
        check("col_c1_mwr", 32'(mem_write), 1);
        check("col_c1_mrd", 32'(mem_read), 0);
        check("col_c1_addr", 32'(mem_address), 32'h40);
        check("col_c1_wd", mem_wrdata, 32'hDEAD_BEEF);
        tick(); @(negedge clk);
        check("col_c2_mwr", 32'(mem_write), 1);
        tick(); @(negedge clk);
        check("col_c3_dstall", 32'(dbus_stall), 0);
        check("col_c3_istall", 32'(ibus_stall), 1);
        tick(); dbus_write = 0;
        @(negedge clk);
        check("col_c4_mrd", 32'(mem_read), 1);
        check("col_c4_addr", 32'(mem_address), 32'h4);
        check("col_c4_istall", 32'(ibus_stall), 1);
        tick(); @(negedge clk);
        check("col_c5_mrd", 32'(mem_read), 1);
        tick(); @(negedge clk);
        check("col_c6_istall", 32'(ibus_stall), 0);
        check("col_c6_data", ibus_rddata, 32'h2402_0005);
        tick(); ibus_read = 0;
        tick();

        // Byte write then read-back of the same word
        dbus_write = 1; dbus_address = 32'h203; dbus_byteenable = 4'b0010; dbus_wrdata = 32'hAABB_CCDD;
        tick(); @(negedge clk);
        check("bw_addr", 32'(mem_address), 32'h80);
        check("bw_be", 32'(mem_byteenable), 32'h2);
        tick(); tick(); @(negedge clk);
        check("bw_done", 32'(dbus_stall), 0);
        check("bw_keep_rd", dbus_rddata, 32'h2402_0005);
        tick();
        dbus_write = 0; dbus_read = 1; dbus_address = 32'h200; dbus_byteenable = 4'hF;
        tick(); tick(); tick(); @(negedge clk);
        check("br_done", 32'(dbus_stall), 0);
        check("br_data", dbus_rddata, 32'h1122_CC44);
        tick(); dbus_read = 0;
        tick();

        // Reset during first BUSY cycle
        dbus_write = 1; dbus_address = 32'h210; dbus_wrdata = 32'h1234_5678; dbus_byteenable = 4'hF;
        tick(); @(negedge clk);
        check("ra_c1_mwr", 32'(mem_write), 1);
        rst_n = 0;
        tick(); @(negedge clk);
        check("ra_c2_mwr", 32'(mem_write), 0);
        check("ra_c2_rddata", dbus_rddata, 0);
        check("ra_c2_nodone", 32'(dbus_stall), 1);
        dbus_write = 0; rst_n = 1;
        tick(); @(negedge clk);
        check("ra_c3_mwr", 32'(mem_write), 0);
        check("ra_c3_stall", 32'(dbus_stall), 0);
        tick();

        // Wait-state extremes (0 and 7)
        s_read = 1; first0 = -1; first7 = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (!s0_dstall && first0 < 0) first0 = c;
            if (!s7_dstall && first7 < 0) first7 = c;
            if (c == 1) check("ws0_c1_mrd", 32'(s0_mrd), 1);
            if (c == 8) check("ws7_c8_mrd", 32'(s7_mrd), 1);
            tick();
        end
        s_read = 0;
        check("ws0_done_cycle", 32'(first0), 2);
        check("ws7_done_cycle", 32'(first7), 9);
        check("ws0_data", s0_rddata, SHORT_DATA);
        check("ws7_data", s7_rddata, SHORT_DATA);

        // Randomized traffic from a fresh reset
        rst_n = 0; tick(); rst_n = 1;
        cont = 1; abort = 0; ncomp = 0; last_owner = -1; last_rd = 0;
        new_req(0); new_req(1); apply();
        for (int cyc = 0; cyc < 1500 && !abort; cyc++) begin
            @(negedge clk);
            check("mem_excl", 32'(mem_read & mem_write), 0);
            check("rd_mirror", ibus_rddata, dbus_rddata);
            for (int p = 0; p < 2; p++) begin
                stl = (p == 1) ? dbus_stall : ibus_stall;
                rd  = (p == 1) ? dbus_rddata : ibus_rddata;
                if (!act[p]) begin
                    check("idle_stall", 32'(stl), 0);
                end else begin
                    lat[p]++;
                    if (stl) begin
                        if (lat[p] > BOUND) begin
                            check("latency_ok", 0, 1);
                            abort = 1;
                        end
                    end else begin
                        check("latency_ok", 32'(lat[p] - 1 <= BOUND), 1);
                        if (wr[p]) begin
                            check("wr_keeps_rd", rd, last_rd);
                            shadow[adr[p][9:2]] = merge(shadow[adr[p][9:2]], wd[p], bes[p]);
                        end else begin
                            check("rd_data", rd, shadow[adr[p][9:2]]);
                            last_rd = shadow[adr[p][9:2]];
                        end
                        if (cont && last_owner < 0) check("first_dbus", 32'(p), 1);
                        if (cont && last_owner >= 0) check("alternate", 32'(p), 32'(1 - last_owner));
                        last_owner = p;
                        ncomp++;
                        if (ncomp == 20) cont = 0;
                        act[p] = 0;
                    end
                end
            end
            tick();
            for (int p = 0; p < 2; p++)
                if (!act[p] && (cont || $urandom_range(1) == 1)) new_req(p);
            apply();
        end
        check("completions", 32'(ncomp > 40), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
